// File: rtl/i2s_frame_lock_ctrl.sv
// Frame-lock controller for the I2S-to-16LJ path: measures BCK cycles per LRCK
// half-frame, qualifies 16/24/32-bit formats, and drives mute and frame-start resync.
module i2s_frame_lock_ctrl #(
  parameter int LOCK_HALVES   = 8,
  parameter int UNMUTE_HALVES = 4,
  parameter int TIMEOUT       = 64,
  parameter int ERR_W         = 8
) (
  input  logic             bck,
  input  logic             rst_n,
  input  logic             lrck_in,
  output logic             locked,
  output logic             mute,
  output logic [5:0]       half_bits,
  output logic             frame_start,
  output logic             channel,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam logic [6:0] LOCK_TGT   = 7'(LOCK_HALVES);
  localparam logic [5:0] UNMUTE_TGT = 6'(UNMUTE_HALVES);
  localparam logic [6:0] STALL_CNT  = 7'(TIMEOUT);
  localparam logic [6:0] CNT_MAX    = 7'd127;

  state_t           state, state_n;
  logic             lrck_d;
  logic [6:0]       bit_cnt;
  logic             first_seen;
  logic [5:0]       cand, cand_n;
  logic [5:0]       match_cnt, match_n;
  logic [5:0]       unmute_cnt, unmute_n;
  logic [5:0]       half_n;
  logic [ERR_W-1:0] err_n;
  logic             fs_n;

  logic lrck_edge, eval_edge, stall, len_valid;

  assign lrck_edge = (lrck_in != lrck_d);
  // The very first edge after reset bounds no complete half-frame, so it is only armed.
  assign eval_edge = lrck_edge && first_seen;
  assign stall     = !lrck_edge && (bit_cnt == STALL_CNT);
  assign len_valid = (bit_cnt == 7'd16) || (bit_cnt == 7'd24) || (bit_cnt == 7'd32);
  assign channel   = lrck_d;

  // NOTE: every variable is given a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_n  = state;
    cand_n   = cand;
    match_n  = match_cnt;
    unmute_n = unmute_cnt;
    half_n   = half_bits;
    err_n    = err_cnt;
    fs_n     = 1'b0;
    case (state)
      ST_SEARCH: begin
        if (eval_edge && len_valid) begin
          cand_n  = bit_cnt[5:0];
          match_n = 6'd1;
          state_n = ST_ACQUIRE;
        end
      end
      ST_ACQUIRE: begin
        if (eval_edge) begin
          if (bit_cnt == {1'b0, cand}) begin
            if (({1'b0, match_cnt} + 7'd1) == LOCK_TGT) begin
              state_n  = ST_LOCKED;
              half_n   = cand;
              unmute_n = 6'd0;
            end else begin
              match_n = match_cnt + 6'd1;
            end
          end else if (len_valid) begin
            cand_n  = bit_cnt[5:0];
            match_n = 6'd1;
          end else begin
            state_n = ST_SEARCH;
            match_n = 6'd0;
          end
        end else if (stall) begin
          state_n = ST_SEARCH;
          match_n = 6'd0;
        end
      end
      ST_LOCKED: begin
        if (eval_edge && (bit_cnt == {1'b0, half_bits})) begin
          fs_n = 1'b1;
          if (unmute_cnt != UNMUTE_TGT) unmute_n = unmute_cnt + 6'd1;
        end else if (eval_edge || stall) begin
          state_n = ST_SEARCH;
          half_n  = 6'd0;
          if (err_cnt != '1) err_n = err_cnt + 1'b1;
        end
      end
      default: state_n = ST_SEARCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge bck or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_SEARCH;
      lrck_d      <= 1'b0;
      bit_cnt     <= 7'd1;
      first_seen  <= 1'b0;
      cand        <= 6'd0;
      match_cnt   <= 6'd0;
      unmute_cnt  <= 6'd0;
      half_bits   <= 6'd0;
      err_cnt     <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      mute        <= 1'b1;
    end else begin
      state       <= state_n;
      lrck_d      <= lrck_in;
      first_seen  <= first_seen | lrck_edge;
      cand        <= cand_n;
      match_cnt   <= match_n;
      unmute_cnt  <= unmute_n;
      half_bits   <= half_n;
      err_cnt     <= err_n;
      frame_start <= fs_n;
      if (lrck_edge)              bit_cnt <= 7'd1;
      else if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 7'd1;
      // Both decode the current state so lock loss drops locked and raises mute together.
      locked      <= (state == ST_LOCKED);
      mute        <= !((state == ST_LOCKED) && (unmute_cnt == UNMUTE_TGT));
    end
  end

endmodule

// File: tb/tb_i2s_frame_lock_ctrl.sv
// Directed bench for i2s_frame_lock_ctrl; a second instance with ERR_W=2 shares
// the stimulus to observe error-counter saturation.
module tb_i2s_frame_lock_ctrl;

  logic       bck = 1'b0;
  logic       rst_n = 1'b0;
  logic       lrck = 1'b0;
  logic       locked_a, mute_a, fs_a, ch_a;
  logic [5:0] half_a;
  logic [7:0] err_a;
  logic       locked_b, mute_b, fs_b, ch_b;
  logic [5:0] half_b;
  logic [1:0] err_b;

  int n_checks = 0;
  int n_pass   = 0;
  int fs_cnt   = 0;

  i2s_frame_lock_ctrl dut_a (
    .bck(bck), .rst_n(rst_n), .lrck_in(lrck), .locked(locked_a), .mute(mute_a),
    .half_bits(half_a), .frame_start(fs_a), .channel(ch_a), .err_cnt(err_a)
  );

  i2s_frame_lock_ctrl #(.ERR_W(2)) dut_b (
    .bck(bck), .rst_n(rst_n), .lrck_in(lrck), .locked(locked_b), .mute(mute_b),
    .half_bits(half_b), .frame_start(fs_b), .channel(ch_b), .err_cnt(err_b)
  );

  always #5 bck = ~bck;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance n clocks, sampling 1 time unit after each rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge bck);
      #1;
      if (fs_a) fs_cnt++;
    end
  endtask

  // Toggle LRCK, then hold it for n clocks: the next toggle measures L = n.
  task automatic halves(input int count, input int n);
    repeat (count) begin
      lrck = ~lrck;
      tick(n);
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    lrck  = 1'b0;
    tick(2);
    rst_n  = 1'b1;
    fs_cnt = 0;
  endtask

  initial begin
    // Reset values
    tick(2);
    check("rst_locked", locked_a, 0);
    check("rst_mute", mute_a, 1);
    check("rst_half", half_a, 0);
    check("rst_fs", fs_a, 0);
    check("rst_channel", ch_a, 0);
    check("rst_err", err_a, 0);
    rst_n = 1'b1;

    // Steady 32-bit: discarded edge + 8 matching edges to lock
    halves(8, 32);
    check("t32_not_yet", locked_a, 0);
    check("t32_half_unlocked", half_a, 0);
    halves(1, 32);
    check("t32_locked", locked_a, 1);
    check("t32_half", half_a, 32);
    check("t32_mute_held", mute_a, 1);
    check("t32_channel", ch_a, 1);
    check("t32_no_fs_on_lock", fs_cnt, 0);
    halves(3, 32);
    check("t32_mute_3", mute_a, 1);
    halves(1, 32);
    check("t32_unmute", mute_a, 0);
    check("t32_fs_count", fs_cnt, 4);
    halves(4, 32);
    check("t32_fs_count8", fs_cnt, 8);

    // 24-bit lock, then switch to 16
    do_reset();
    halves(9, 24);
    check("t24_locked", locked_a, 1);
    check("t24_half", half_a, 24);
    halves(2, 16);
    check("t16_loss_locked", locked_a, 0);
    check("t16_loss_mute", mute_a, 1);
    check("t16_loss_half", half_a, 0);
    check("t16_loss_err", err_a, 1);
    check("t16_loss_err_b", err_b, 1);
    halves(7, 16);
    check("t16_not_yet", locked_a, 0);
    halves(1, 16);
    check("t16_relock", locked_a, 1);
    check("t16_half", half_a, 16);
    check("t16_err_kept", err_a, 1);

    // 20-bit halves never qualify
    do_reset();
    halves(100, 20);
    check("t20_locked", locked_a, 0);
    check("t20_mute", mute_a, 1);
    check("t20_err", err_a, 0);
    check("t20_half", half_a, 0);

    // Stall while locked at 32
    do_reset();
    halves(9, 32);
    check("stall_pre_locked", locked_a, 1);
    halves(1, 60);
    check("stall_hold60", locked_a, 1);
    tick(20);
    check("stall_locked", locked_a, 0);
    check("stall_mute", mute_a, 1);
    check("stall_half", half_a, 0);
    check("stall_err", err_a, 1);

    // Relock after the stall, then reset mid-frame
    halves(9, 32);
    check("mid_relocked", locked_a, 1);
    lrck = ~lrck;
    tick(10);
    rst_n = 1'b0;
    lrck  = 1'b0;
    #1;
    check("mid_locked", locked_a, 0);
    check("mid_mute", mute_a, 1);
    check("mid_half", half_a, 0);
    check("mid_fs", fs_a, 0);
    check("mid_channel", ch_a, 0);
    check("mid_err", err_a, 0);
    tick(2);
    rst_n  = 1'b1;
    fs_cnt = 0;
    halves(8, 32);
    check("mid_not_yet", locked_a, 0);
    halves(1, 32);
    check("mid_reacquired", locked_a, 1);

    // Acquire 32,32,32 then switch to 24: candidate restarts at 24
    do_reset();
    halves(3, 32);
    halves(8, 24);
    check("acq_not_yet", locked_a, 0);
    halves(1, 24);
    check("acq_locked", locked_a, 1);
    check("acq_half", half_a, 24);

    // Five lock losses: 8-bit counter reaches 5, 2-bit counter saturates at 3
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      halves(9, 32);
      check("sat_locked", locked_a, 1);
      tick(40);
      check("sat_err_a", err_a, i);
      check("sat_err_b", err_b, (i > 3) ? 3 : i);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2s_frame_lock_ctrl.md
Name: i2s_frame_lock_ctrl

Overview:
- Frame-lock controller for the I2S-to-16LJ converter path, clocked by the incoming bit clock.
- Measures the BCK cycles per LRCK half-frame and qualifies the 16-, 24- or 32-bit I2S formats.
- Runs a search/acquire/locked state machine and drives the converter's mute and per-half frame-start resync.
- Counts lock losses so firmware/debug can see source instability.

Parameters:
- LOCK_HALVES, 8: consecutive matching valid half-frames required to declare lock (2..63).
- UNMUTE_HALVES, 4: half-frames after lock before mute releases (1..63).
- TIMEOUT, 64: bit_cnt value at which a missing LRCK edge counts as a stall (33..127).
- ERR_W, 8: width of the lock-loss counter.

Ports:
- bck  input  1  I2S bit clock; sole clock, all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- lrck_in  input  1  raw I2S LRCK, synchronous to bck.
- locked  output  1  high while in LOCKED.
- mute  output  1  converter output mute; high unless locked and unmute delay elapsed.
- half_bits  output  6  locked half-frame length (16/24/32); 0 when not locked.
- frame_start  output  1  one-cycle pulse on each LRCK edge while LOCKED.
- channel  output  1  registered LRCK level (lrck_d).
- err_cnt  output  ERR_W  saturating count of LOCKED->SEARCH transitions.

Behaviour:
- Reset (async, rst_n=0): state=SEARCH; lrck_d=0; bit_cnt=1; first_seen=0; cand=0; match_cnt=0; unmute_cnt=0; err_cnt=0.
- Reset output values: locked=0, mute=1, half_bits=0, frame_start=0, channel=0.
- Edge detect: edge = (lrck_in != lrck_d); lrck_d <= lrck_in every cycle.
- bit_cnt: on edge, <=1; otherwise increments, saturating at 127.
- Measured length: L = bit_cnt sampled on an edge cycle. A 32-bit half gives L=32.
- valid(L) = L in {16,24,32}.
- First edge after reset sets first_seen=1 and is never evaluated.
- Stall: no edge and bit_cnt==TIMEOUT. An edge in the same cycle takes priority; its L is evaluated normally (invalid, since TIMEOUT>32).
- SEARCH:
  - evaluated edge with valid L: cand<=L, match_cnt<=1, go ACQUIRE.
  - otherwise stay.
- ACQUIRE:
  - edge with L==cand and match_cnt+1==LOCK_HALVES: go LOCKED, half_bits<=cand, unmute_cnt<=0.
  - edge with L==cand otherwise: match_cnt++.
  - edge with L!=cand and valid L: cand<=L, match_cnt<=1, stay in ACQUIRE.
  - edge with invalid L, or stall: go SEARCH, match_cnt<=0.
- LOCKED:
  - edge with L==half_bits: frame_start=1 that cycle (registered, so visible one cycle after the edge cycle); unmute_cnt++ saturating at UNMUTE_HALVES.
  - edge with L!=half_bits, or stall: go SEARCH, half_bits<=0, err_cnt++ (saturate at all-ones), no frame_start.
- The edge that enters LOCKED does not generate frame_start; the first pulse comes on the next matching edge.
- locked is a registered decode of state==LOCKED.
- mute <= !(state==LOCKED && unmute_cnt==UNMUTE_HALVES). On lock loss, mute rises the same cycle locked falls.
- Total latency from the first evaluated edge to locked=1: LOCK_HALVES-1 further matching edges, plus one register cycle.
- mute falls UNMUTE_HALVES matching edges after lock.
- Mid-operation reset returns everything to the reset values immediately; the next edge only sets first_seen.

Test Plan:
- Steady 32-bit I2S (LRCK toggles every 32 bck), LOCK_HALVES=8: locked rises after the 9th edge (1 discarded + 8); half_bits=32; mute falls after 4 more edges; frame_start pulses every 32 cycles.
- 24-bit halves: lock as above with half_bits=24; switching to 16-bit halves while locked gives locked=0, err_cnt=1; relock with half_bits=16 after 8 more edges.
- 20-bit halves for 100 edges: state never leaves SEARCH; locked=0, mute=1, err_cnt=0.
- Locked at 32, then LRCK held for 80 cycles: at bit_cnt==64, locked=0, mute=1, half_bits=0, err_cnt increments by 1.
- ACQUIRE with 32,32,32 then 24: cand=24, match_cnt=1; needs 7 more 24s to lock.
- Assert rst_n low mid-frame while locked: all outputs return to reset values asynchronously; err_cnt=0; after release, first edge ignored, lock reacquired normally.
- ERR_W=2, force 5 lock losses: err_cnt saturates at 3.
